demux1to2_stream: RTL and testbench

- Registered 1-to-2 stream demultiplexer, the inverse of the 8-bit 2:1 mux.
- Routes a single valid/ready input stream to one of two output streams.
- Routing is chosen per packet by `sel` and locked until the last beat.
- Sits at fan-out points where one producer feeds two consumers. Each output has a single register stage, so backpressure on one consumer never corrupts the other.

---
 rtl/demux1to2_stream.sv | 138 +++++++++++++
 tb/tb_demux1to2_stream.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/demux1to2_stream.sv
// Registered 1-to-2 valid/ready stream demultiplexer; routing is locked per packet.
// Optional beat counters on cnt1/cnt2 are built when DEMUX_STATS_EN is defined.
module demux1to2_stream #(
    parameter int INPUT_WIDTH = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INPUT_WIDTH-1:0] in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    input  logic                   sel,
    output logic [INPUT_WIDTH-1:0] out1_data,
    output logic                   out1_valid,
    output logic                   out1_last,
    input  logic                   out1_ready,
    output logic [INPUT_WIDTH-1:0] out2_data,
    output logic                   out2_valid,
    output logic                   out2_last,
    input  logic                   out2_ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]   cnt1,
    output logic [CNT_WIDTH-1:0]   cnt2
`endif
);

    typedef enum logic [1:0] {IDLE, ROUTE1, ROUTE2} state_t;

    state_t                 state_q, state_d;
    logic [INPUT_WIDTH-1:0] out1_data_q, out1_data_d, out2_data_q, out2_data_d;
    logic                   out1_valid_q, out1_valid_d, out2_valid_q, out2_valid_d;
    logic                   out1_last_q, out1_last_d, out2_last_q, out2_last_d;
    logic                   tgt1;
    logic                   accept;

    // In IDLE the target follows sel live, so a stalled first beat can be retargeted.
    always_comb begin
        case (state_q)
            IDLE:    tgt1 = sel;
            ROUTE1:  tgt1 = 1'b1;
            default: tgt1 = 1'b0;
        endcase
    end

    assign in_ready = tgt1 ? (!out1_valid_q || out1_ready) : (!out2_valid_q || out2_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        out1_data_d  = out1_data_q;
        out1_valid_d = out1_valid_q;
        out1_last_d  = out1_last_q;
        out2_data_d  = out2_data_q;
        out2_valid_d = out2_valid_q;
        out2_last_d  = out2_last_q;

        if (accept) begin
            if (in_last) begin
                state_d = IDLE;
            end else if (state_q == IDLE) begin
                state_d = sel ? ROUTE1 : ROUTE2;
            end
        end

        if (accept && tgt1) begin
            out1_data_d  = in_data;
            out1_last_d  = in_last;
            out1_valid_d = 1'b1;
        end else if (out1_ready) begin
            out1_valid_d = 1'b0;
        end

        if (accept && !tgt1) begin
            out2_data_d  = in_data;
            out2_last_d  = in_last;
            out2_valid_d = 1'b1;
        end else if (out2_ready) begin
            out2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            out1_data_q  <= '0;
            out1_valid_q <= 1'b0;
            out1_last_q  <= 1'b0;
            out2_data_q  <= '0;
            out2_valid_q <= 1'b0;
            out2_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            out1_data_q  <= out1_data_d;
            out1_valid_q <= out1_valid_d;
            out1_last_q  <= out1_last_d;
            out2_data_q  <= out2_data_d;
            out2_valid_q <= out2_valid_d;
            out2_last_q  <= out2_last_d;
        end
    end

    assign out1_data  = out1_data_q;
    assign out1_valid = out1_valid_q;
    assign out1_last  = out1_last_q;
    assign out2_data  = out2_data_q;
    assign out2_valid = out2_valid_q;
    assign out2_last  = out2_last_q;

`ifdef DEMUX_STATS_EN
    logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;

    // Counters track output-side transfers, so they count beats actually delivered.
    always_comb begin
        cnt1_d = cnt1_q;
        cnt2_d = cnt2_q;
        if (out1_valid_q && out1_ready) cnt1_d = cnt1_q + CNT_WIDTH'(1);
        if (out2_valid_q && out2_ready) cnt2_d = cnt2_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt1_q <= '0;
            cnt2_q <= '0;
        end else begin
            cnt1_q <= cnt1_d;
            cnt2_q <= cnt2_d;
        end
    end

    assign cnt1 = cnt1_q;
    assign cnt2 = cnt2_q;
`else
    localparam int unused_cnt_w = CNT_WIDTH;
`endif

endmodule

// File: tb/tb_demux1to2_stream.sv
// Randomized bench for demux1to2_stream: per-port FIFO scoreboard plus packet routing model.
module tb_demux1to2_stream;
    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          sel = 1'b0;
    logic [DW-1:0] out1_data, out2_data;
    logic          out1_valid, out1_last, out2_valid, out2_last;
    logic          out1_ready = 1'b1;
    logic          out2_ready = 1'b1;
`ifdef DEMUX_STATS_EN
    logic [CW-1:0] cnt1, cnt2;
`endif

    demux1to2_stream #(.INPUT_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .sel(sel),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_last(out1_last), .out1_ready(out1_ready),
        .out2_data(out2_data), .out2_valid(out2_valid), .out2_last(out2_last), .out2_ready(out2_ready)
`ifdef DEMUX_STATS_EN
        , .cnt1(cnt1), .cnt2(cnt2)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: what each port still owes its consumer, and the packet route lock.
    logic [DW:0]   q1[$];
    logic [DW:0]   q2[$];
    logic          locked = 1'b0;
    logic          lock_t = 1'b0;
    logic [CW-1:0] dlv1 = '0;
    logic [CW-1:0] dlv2 = '0;
    logic          mon_en = 1'b0;
    logic          rnd_rdy = 1'b0;

    always @(negedge clk) begin
        if (!rst && mon_en) begin
            logic t, exp_rdy;
            t = locked ? lock_t : sel;
            chk("out1_valid", {31'b0, out1_valid}, {31'b0, q1.size() > 0});
            chk("out2_valid", {31'b0, out2_valid}, {31'b0, q2.size() > 0});
            if (q1.size() > 0) chk("out1_beat", {23'b0, out1_last, out1_data}, {23'b0, q1[0]});
            if (q2.size() > 0) chk("out2_beat", {23'b0, out2_last, out2_data}, {23'b0, q2[0]});
            exp_rdy = t ? (q1.size() == 0 || out1_ready) : (q2.size() == 0 || out2_ready);
            chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
`ifdef DEMUX_STATS_EN
            chk("cnt1", {16'b0, cnt1}, {16'b0, dlv1});
            chk("cnt2", {16'b0, cnt2}, {16'b0, dlv2});
`endif
            if (q1.size() > 0 && out1_ready) begin void'(q1.pop_front()); dlv1++; end
            if (q2.size() > 0 && out2_ready) begin void'(q2.pop_front()); dlv2++; end
            if (in_valid && exp_rdy) begin
                if (t) q1.push_back({in_last, in_data});
                else   q2.push_back({in_last, in_data});
                if (in_last) locked = 1'b0;
                else if (!locked) begin locked = 1'b1; lock_t = sel; end
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1;
            out1_ready = ($urandom_range(0, 3) != 0);
            out2_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic s);
        bit done;
        done = 1'b0;
        in_data = d; in_last = l; sel = s; in_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_packet(input int n, input logic [DW-1:0] base, input logic s, input bit toggle);
        for (int i = 0; i < n; i++) begin
            logic sv;
            sv = (i == 0) ? s : (toggle ? ~s : 1'($urandom_range(0, 1)));
            send_beat(base + DW'(i), (i == n - 1), sv);
        end
    endtask

    task automatic reset_now();
        in_valid = 1'b0;
        rst = 1'b1;
        q1.delete(); q2.delete();
        locked = 1'b0; dlv1 = '0; dlv2 = '0;
        #1;
        chk("rst_out1_valid", {31'b0, out1_valid}, 32'd0);
        chk("rst_out2_valid", {31'b0, out2_valid}, 32'd0);
        chk("rst_out1_last", {31'b0, out1_last}, 32'd0);
        chk("rst_out2_last", {31'b0, out2_last}, 32'd0);
        chk("rst_out1_data", {24'b0, out1_data}, 32'd0);
        chk("rst_out2_data", {24'b0, out2_data}, 32'd0);
`ifdef DEMUX_STATS_EN
        chk("rst_cnt1", {16'b0, cnt1}, 32'd0);
        chk("rst_cnt2", {16'b0, cnt2}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #3;
        reset_now();
        mon_en = 1'b1;

        // Single-beat routing to out1.
        send_beat(8'hA5, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Packet lock: sel flips after the first beat but all beats stay on out2.
        send_packet(4, 8'h10, 1'b0, 1'b1);
        send_beat(8'h55, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure on out1 followed by release.
        out1_ready = 1'b0; out2_ready = 1'b1;
        fork
            send_packet(4, 8'h20, 1'b1, 1'b0);
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("bp_stall_in_ready", {31'b0, in_ready}, 32'd0);
                chk("bp_stall_data", {24'b0, out1_data}, 32'h20);
                repeat (3) @(posedge clk);
                #1;
                out1_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // Independence: stalled out1 beat does not block a packet to out2.
        out1_ready = 1'b0;
        send_beat(8'h30, 1'b1, 1'b1);
        send_packet(3, 8'h40, 1'b0, 1'b0);
        @(negedge clk);
        chk("indep_out1_held", {31'b0, out1_valid}, 32'd1);
        @(posedge clk);
        #1;
        out1_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Mid-packet reset discards everything in flight.
        out1_ready = 1'b0;
        send_beat(8'h61, 1'b0, 1'b1);
        #2;
        reset_now();

        // Every data value on both ports, with random consumer stalls.
        rnd_rdy = 1'b1;
        for (int v = 0; v < 256; v++) begin
            for (int s = 0; s < 2; s++) begin
                send_beat(DW'(v), 1'b1, 1'(s));
            end
        end

        // Random packets with random gaps and sel noise.
        for (int p = 0; p < 150; p++) begin
            send_packet($urandom_range(1, 5), DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        rnd_rdy = 1'b0;
        @(posedge clk);
        #2;
        out1_ready = 1'b1; out2_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("drain_q1_empty", q1.size(), 32'd0);
        chk("drain_q2_empty", q2.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
